// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: ALU opcodes, instruction opcodes,
// controller states and small decode helpers.
package alu_sequencer_pkg;

  localparam logic [3:0] ALUOP_ADD = 4'h0;
  localparam logic [3:0] ALUOP_SUB = 4'h1;
  localparam logic [3:0] ALUOP_PD1 = 4'h5;
  localparam logic [3:0] ALUOP_PD2 = 4'h6;

  localparam logic [3:0] OPC_NOP  = 4'h0;
  localparam logic [3:0] OPC_LDI  = 4'h1;
  localparam logic [3:0] OPC_MOV  = 4'h2;
  localparam logic [3:0] OPC_ADD  = 4'h3;
  localparam logic [3:0] OPC_SUB  = 4'h4;
  localparam logic [3:0] OPC_ADDI = 4'h5;
  localparam logic [3:0] OPC_SUBI = 4'h6;
  localparam logic [3:0] OPC_CMP  = 4'h7;
  localparam logic [3:0] OPC_JMP  = 4'h8;
  localparam logic [3:0] OPC_JZ   = 4'h9;
  localparam logic [3:0] OPC_JNZ  = 4'hA;
  localparam logic [3:0] OPC_JC   = 4'hB;
  localparam logic [3:0] OPC_JS   = 4'hC;
  localparam logic [3:0] OPC_JO   = 4'hD;
  localparam logic [3:0] OPC_OUT  = 4'hE;
  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_OUT,
    ST_HALT
  } state_e;

  typedef struct packed {
    logic [3:0] opc;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
  } instr_t;

  typedef struct packed {
    logic z;
    logic s;
    logic c;
    logic ov;
  } flags_t;

  function automatic logic jcc_taken(input logic [3:0] opc, input flags_t f);
    case (opc)
      OPC_JZ:  return f.z;
      OPC_JNZ: return !f.z;
      OPC_JC:  return f.c;
      OPC_JS:  return f.s;
      OPC_JO:  return f.ov;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_op_of(input logic [3:0] opc);
    case (opc)
      OPC_LDI, OPC_MOV:           return ALUOP_PD2;
      OPC_ADD, OPC_ADDI:          return ALUOP_ADD;
      OPC_SUB, OPC_SUBI, OPC_CMP: return ALUOP_SUB;
      default:                    return ALUOP_PD1;
    endcase
  endfunction

  function automatic logic uses_imm(input logic [3:0] opc);
    return (opc == OPC_LDI) || (opc == OPC_ADDI) || (opc == OPC_SUBI);
  endfunction

  function automatic logic sets_flags(input logic [3:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_ADDI) ||
           (opc == OPC_SUBI) || (opc == OPC_CMP);
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile_4x8.sv
// 4 x 8-bit register file: two combinational read ports, one write port,
// asynchronous active-low reset to zero.
module regfile_4x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ra_addr,
  output logic [7:0] ra_data,
  input  logic [1:0] rb_addr,
  output logic [7:0] rb_data,
  input  logic       we,
  input  logic [1:0] wa,
  input  logic [7:0] wd
);

  logic [7:0] regs_q [4];
  logic [7:0] regs_d [4];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller driving an external 8-bit ALU, with a
// 4x8 register file, conditional jumps on captured flags and an output port.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  output logic [7:0]  o_IMemAddr,
  output logic        o_IMemReq,
  input  logic        i_IMemAck,
  input  logic [15:0] i_IMemData,
  output logic [3:0]  o_ALUOp,
  output logic [7:0]  o_ALUData1,
  output logic [7:0]  o_ALUData2,
  input  logic [7:0]  i_ALUResult,
  input  logic        i_Z,
  input  logic        i_S,
  input  logic        i_C,
  input  logic        i_OF,
  output logic [7:0]  o_OutData,
  output logic        o_OutValid,
  input  logic        i_OutReady,
  output logic        o_Halted
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  instr_t     ir_q, ir_d;
  flags_t     flags_q, flags_d;
  logic       req_q, req_d;
  logic [3:0] alu_op_q, alu_op_d;
  logic [7:0] alu_d1_q, alu_d1_d;
  logic [7:0] alu_d2_q, alu_d2_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       halted_q, halted_d;

  logic [7:0] rd_data, rs_data;
  logic       rf_we;

  regfile_4x8 u_regfile (
    .clk     (i_CLK),
    .rst_n   (i_RST_N),
    .ra_addr (ir_q.rd),
    .ra_data (rd_data),
    .rb_addr (ir_q.rs),
    .rb_data (rs_data),
    .we      (rf_we),
    .wa      (ir_q.rd),
    .wd      (i_ALUResult)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    flags_d     = flags_q;
    req_d       = req_q;
    alu_op_d    = alu_op_q;
    alu_d1_d    = alu_d1_q;
    alu_d2_d    = alu_d2_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    halted_d    = halted_q;
    rf_we       = 1'b0;

    // Every transition into FETCH raises req in the same edge, so the
    // request appears one cycle earlier than a separate request state would.
    case (state_q)
      ST_FETCH: begin
        req_d = 1'b1;
        if (req_q && i_IMemAck) begin
          ir_d    = i_IMemData;
          pc_d    = pc_q + 8'd1;
          req_d   = 1'b0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (ir_q.opc)
          OPC_NOP, OPC_JMP, OPC_JZ, OPC_JNZ, OPC_JC, OPC_JS, OPC_JO: begin
            if ((ir_q.opc == OPC_JMP) || jcc_taken(ir_q.opc, flags_q)) pc_d = ir_q.imm;
            req_d   = 1'b1;
            state_d = ST_FETCH;
          end
          OPC_OUT: begin
            out_data_d  = rd_data;
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
          end
          OPC_HALT: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            alu_op_d = alu_op_of(ir_q.opc);
            alu_d1_d = rd_data;
            alu_d2_d = uses_imm(ir_q.opc) ? ir_q.imm : rs_data;
            state_d  = ST_EXEC;
          end
        endcase
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        rf_we = (ir_q.opc != OPC_CMP);
        if (sets_flags(ir_q.opc)) flags_d = '{z: i_Z, s: i_S, c: i_C, ov: i_OF};
        req_d   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_OUT: begin
        if (i_OutReady) begin
          out_valid_d = 1'b0;
          req_d       = 1'b1;
          state_d     = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      flags_q     <= '0;
      req_q       <= 1'b0;
      alu_op_q    <= ALUOP_PD1;
      alu_d1_q    <= '0;
      alu_d2_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      flags_q     <= flags_d;
      req_q       <= req_d;
      alu_op_q    <= alu_op_d;
      alu_d1_q    <= alu_d1_d;
      alu_d2_q    <= alu_d2_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign o_IMemAddr = pc_q;
  assign o_IMemReq  = req_q;
  assign o_ALUOp    = alu_op_q;
  assign o_ALUData1 = alu_d1_q;
  assign o_ALUData2 = alu_d2_q;
  assign o_OutData  = out_data_q;
  assign o_OutValid = out_valid_q;
  assign o_Halted   = halted_q;

endmodule
